// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller: state encodings and
// divisor constants.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEFAULT_DIV = 1999;
  localparam int MIN_DIV     = 1;

endpackage

// File: rtl/clk_div_core.sv
// Divide counter with terminal-count compare and output toggle. While run is
// low the counter and the divided clock are held at zero.
module clk_div_core #(
  parameter int CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             clk_o,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a counter beyond div can never run away.
  assign tc = run && (cnt >= div);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      clk_o <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      clk_o <= 1'b0;
    end else if (tc) begin
      cnt   <= '0;
      clk_o <= ~clk_o;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/reload/drain controller for a glitch-free programmable clock divider.
// Optional one-shot mode is compiled in with CLK_DIV_CTRL_ONESHOT_EN.
module clk_div_ctrl #(
  parameter int CNT_W       = 11,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             load_i,
`ifdef CLK_DIV_CTRL_ONESHOT_EN
  input  logic             oneshot_i,
`endif
  output logic             load_ack_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  import clk_div_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] div_in;
  logic             pend;
  logic             load_ack;
  logic             tick;
  logic             clk_q;
  logic             tc;
  logic             run;
  logic             stop_now;
  logic             finish;
  logic             to_idle;
  logic             start;
  logic             os_done;

  assign div_in = (div_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_i;

`ifdef CLK_DIV_CTRL_ONESHOT_EN
  logic oneshot_q;
  logic toggled;
  logic armed;

  assign start   = en_i && armed;
  assign os_done = oneshot_q && toggled;
`else
  assign start   = en_i;
  assign os_done = 1'b0;
`endif

  // Low-phase stops cut off immediately (suppressing any coincident toggle);
  // high-phase stops end on the falling toggle at a terminal count.
  always_comb begin
    stop_now = 1'b0;
    finish   = 1'b0;
    stop_now = ((state == ST_RUN) || (state == ST_PEND)) && !en_i && !clk_q;
    finish   = tc && ((state == ST_DRAIN) ? !en_i : (!en_i || os_done));
    to_idle  = stop_now || finish;
    run      = (state != ST_IDLE) && !stop_now;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      div_reg   <= CNT_W'(DEFAULT_DIV);
      shadow    <= CNT_W'(DEFAULT_DIV);
      pend      <= 1'b0;
      load_ack  <= 1'b0;
      tick      <= 1'b0;
`ifdef CLK_DIV_CTRL_ONESHOT_EN
      oneshot_q <= 1'b0;
      toggled   <= 1'b0;
      armed     <= 1'b1;
`endif
    end else begin
      load_ack <= 1'b0;
      tick     <= tc;
      if (state == ST_IDLE) begin
        if (load_i) begin
          div_reg  <= div_in;
          load_ack <= 1'b1;
        end
        if (start) state <= ST_RUN;
      end else if (to_idle) begin
        state <= ST_IDLE;
        pend  <= 1'b0;
        if (load_i) begin
          div_reg  <= div_in;
          load_ack <= 1'b1;
        end else if (pend) begin
          div_reg  <= shadow;
          load_ack <= 1'b1;
        end
      end else begin
        if (tc && pend) begin
          div_reg  <= shadow;
          load_ack <= 1'b1;
        end
        if (load_i) begin
          shadow <= div_in;
          pend   <= 1'b1;
        end else if (tc) begin
          pend   <= 1'b0;
        end
        if (!en_i)                         state <= ST_DRAIN;
        else if (load_i || (pend && !tc))  state <= ST_PEND;
        else                               state <= ST_RUN;
      end
`ifdef CLK_DIV_CTRL_ONESHOT_EN
      if (state == ST_IDLE) begin
        toggled <= 1'b0;
        if (!en_i) armed <= 1'b1;
        if (start) oneshot_q <= oneshot_i;
      end else begin
        if (tc) toggled <= 1'b1;
        // Only a completed one-shot reaches IDLE with en_i still high.
        if (to_idle && en_i) armed <= 1'b0;
      end
`endif
    end
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run   (run),
    .div   (div_reg),
    .clk_o (clk_q),
    .tc    (tc)
  );

  assign clk_o      = clk_q;
  assign tick_o     = tick;
  assign load_ack_o = load_ack;
  assign busy_o     = (state != ST_IDLE);
  assign state_o    = state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed load/run/drain/reload/reset sequences with
// expected tick and ack events queued and matched by a monitor.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [10:0] div_i;
  logic        load_i;
  logic        load_ack_o;
  logic        clk_o;
  logic        tick_o;
  logic        busy_o;
  logic [1:0]  state_o;
`ifdef CLK_DIV_CTRL_ONESHOT_EN
  logic        oneshot_i;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int s;

  // tick entry: {clk_o level after toggle, cycle}; ack entry: {div_reg, cycle}
  logic [31:0] tick_exp_q[$];
  logic [42:0] ack_exp_q[$];
  logic [31:0] tick_e;
  logic [42:0] ack_e;

  clk_div_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en_i),
    .div_i      (div_i),
    .load_i     (load_i),
`ifdef CLK_DIV_CTRL_ONESHOT_EN
    .oneshot_i  (oneshot_i),
`endif
    .load_ack_o (load_ack_o),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input bit lvl);
    tick_exp_q.push_back({lvl, c[30:0]});
  endtask

  task automatic push_ack(input int c, input int d);
    ack_exp_q.push_back({d[10:0], c});
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (tick_o) begin
      if (tick_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick_unexpected: tick at cycle %0d with nothing expected", cyc);
      end else begin
        tick_e = tick_exp_q.pop_front();
        check("tick_cycle", 32'(cyc), {1'b0, tick_e[30:0]});
        check("tick_level", {31'd0, clk_o}, {31'd0, tick_e[31]});
      end
    end
    if (load_ack_o) begin
      if (ack_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: ack at cycle %0d with nothing expected", cyc);
      end else begin
        ack_e = ack_exp_q.pop_front();
        check("ack_cycle", 32'(cyc), ack_e[31:0]);
        check("ack_div", 32'(dut.div_reg), {21'd0, ack_e[42:32]});
      end
    end
  end

  // driver
  initial begin
    rst = 1'b1; en_i = 1'b0; load_i = 1'b0; div_i = '0;
`ifdef CLK_DIV_CTRL_ONESHOT_EN
    oneshot_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_clk", {31'd0, clk_o}, 0);
    check("rst_tick", {31'd0, tick_o}, 0);
    check("rst_ack", {31'd0, load_ack_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_state", {30'd0, state_o}, 0);
    check("rst_div", 32'(dut.div_reg), 1999);
    rst = 1'b0;
    @(negedge clk);

    // basic run with div 3, then drain from the high phase
    s = cyc;
    load_i = 1'b1; div_i = 11'd3;
    push_ack(s + 1, 3);
    @(negedge clk);
    load_i = 1'b0; en_i = 1'b1;
    s = s + 2;
    push_tick(s + 4, 1); push_tick(s + 8, 0); push_tick(s + 12, 1); push_tick(s + 16, 0);
    at(s + 13); en_i = 1'b0;
    at(s + 14);
    check("drain_state", {30'd0, state_o}, 3);
    check("drain_clk_high", {31'd0, clk_o}, 1);
    at(s + 16);
    check("drain_busy", {31'd0, busy_o}, 0);
    check("drain_clk_low", {31'd0, clk_o}, 0);

    // clamp + double load in PEND, live reloads, load coincident with tc
    at(s + 20);
    en_i = 1'b1;
    s = cyc + 1;
    push_tick(s + 4, 1);
    push_tick(s + 8, 0);  push_ack(s + 8, 5);
    push_tick(s + 14, 1); push_tick(s + 20, 0);
    push_tick(s + 26, 1); push_ack(s + 26, 3);
    push_tick(s + 30, 0); push_tick(s + 34, 1);
    push_tick(s + 38, 0); push_ack(s + 38, 1);
    push_tick(s + 40, 1); push_tick(s + 42, 0); push_tick(s + 44, 1);
    push_tick(s + 46, 0); push_ack(s + 46, 2);
    push_tick(s + 49, 1); push_ack(s + 49, 4);
    push_tick(s + 54, 0); push_tick(s + 59, 1);
    at(s + 5);  load_i = 1'b1; div_i = 11'd0;
    at(s + 6);  div_i = 11'd5;
    at(s + 7);  load_i = 1'b0;
    check("double_load_pend", {30'd0, state_o}, 2);
    at(s + 21); load_i = 1'b1; div_i = 11'd3;
    at(s + 22); load_i = 1'b0;
    at(s + 35); load_i = 1'b1; div_i = 11'd1;
    at(s + 36); load_i = 1'b0;
    check("reload_pend", {30'd0, state_o}, 2);
    at(s + 39);
    check("reload_run", {30'd0, state_o}, 1);
    at(s + 44); load_i = 1'b1; div_i = 11'd2;
    at(s + 45); div_i = 11'd4;
    at(s + 46); load_i = 1'b0;
    at(s + 47);
    check("coincide_pend", {30'd0, state_o}, 2);
    at(s + 50);
    check("coincide_run", {30'd0, state_o}, 1);

    // async reset while a reload is pending
    at(s + 60); load_i = 1'b1; div_i = 11'd7;
    at(s + 61); load_i = 1'b0;
    check("pre_rst_pend", {30'd0, state_o}, 2);
    check("pre_rst_clk", {31'd0, clk_o}, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_clk", {31'd0, clk_o}, 0);
    check("mid_rst_state", {30'd0, state_o}, 0);
    check("mid_rst_busy", {31'd0, busy_o}, 0);
    check("mid_rst_div", 32'(dut.div_reg), 1999);
    en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // pending shadow applied on a low-phase stop, then clamp of 0 in IDLE
    s = cyc;
    load_i = 1'b1; div_i = 11'd2;
    push_ack(s + 1, 2);
    @(negedge clk);
    load_i = 1'b0; en_i = 1'b1;
    s = s + 2;
    push_tick(s + 3, 1); push_tick(s + 6, 0);
    push_ack(s + 9, 4);
    push_ack(s + 12, 1);
    at(s + 7);  load_i = 1'b1; div_i = 11'd4;
    at(s + 8);  load_i = 1'b0; en_i = 1'b0;
    at(s + 9);
    check("stop_busy", {31'd0, busy_o}, 0);
    check("stop_clk", {31'd0, clk_o}, 0);
    at(s + 11); load_i = 1'b1; div_i = 11'd0;
    at(s + 12); load_i = 1'b0; en_i = 1'b1;
    s = s + 13;
    push_tick(s + 2, 1); push_tick(s + 4, 0); push_tick(s + 6, 1); push_tick(s + 8, 0);
    at(s + 6); en_i = 1'b0;
    at(s + 7);
    check("short_drain_state", {30'd0, state_o}, 3);
    at(s + 8);
    check("short_drain_busy", {31'd0, busy_o}, 0);

`ifdef CLK_DIV_CTRL_ONESHOT_EN
    // one-shot: one full period then IDLE while en_i stays high
    at(s + 10); load_i = 1'b1; div_i = 11'd2;
    push_ack(s + 11, 2);
    at(s + 11); load_i = 1'b0; oneshot_i = 1'b1; en_i = 1'b1;
    s = s + 12;
    push_tick(s + 3, 1); push_tick(s + 6, 0);
    at(s + 7);
    check("oneshot_idle", {30'd0, state_o}, 0);
    at(s + 20);
    check("oneshot_stays_idle", {30'd0, state_o}, 0);
    en_i = 1'b0; oneshot_i = 1'b0;
`endif

    repeat (6) @(negedge clk);
    check("tick_queue_left", tick_exp_q.size(), 0);
    check("ack_queue_left", ack_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
